regfile_write_arbiter: RTL and testbench

Shares the single register-file write port (RegWrite/RD/WriteData) between two writeback sources. Source 0 is the in-order pipeline WB stage; source 1 is the multi-cycle unit (divider/long-latency load). Source 1 is buffered in a 2-entry FIFO. Source 0 has priority, except that a bounded-starvation rule forces a source-1 grant. The block also exports a pending-destination mask for the hazard-detection unit.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_write_arbiter_if.sv | 37 +++
 rtl/mc_wb_fifo.sv | 73 +++++++
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file types and sizes
package regfile_pkg;

  localparam int XLEN       = 64;
  localparam int REG_AW     = 5;
  localparam int NUM_REGS   = 32;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    SRC_WB = 1'b0,
    SRC_MC = 1'b1
  } wb_src_e;

  // x0 is hardwired to zero, so it can never be a pending destination.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    logic [NUM_REGS-1:0] mask;
    mask     = '0;
    mask[rd] = 1'b1;
    mask[0]  = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback sources, register-file port and hazard tap
interface regfile_write_arbiter_if #(
  parameter int XLEN = regfile_pkg::XLEN
);
  import regfile_pkg::*;

  logic              wb_valid;
  logic              wb_ready;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              mc_valid;
  logic              mc_ready;
  logic [REG_AW-1:0] mc_rd;
  logic [XLEN-1:0]   mc_data;

  logic                RegWrite;
  logic [REG_AW-1:0]   RD;
  logic [XLEN-1:0]     WriteData;
  logic                grant_src;
  logic [NUM_REGS-1:0] mc_pending;

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  mc_valid, mc_rd, mc_data,
    output wb_ready, mc_ready,
    output RegWrite, RD, WriteData, grant_src, mc_pending
  );

  modport master (
    output wb_valid, wb_rd, wb_data,
    output mc_valid, mc_rd, mc_data,
    input  wb_ready, mc_ready,
    input  RegWrite, RD, WriteData, grant_src, mc_pending
  );

endinterface

// File: rtl/mc_wb_fifo.sv
// rtl/mc_wb_fifo.sv - 2-entry FIFO for multi-cycle writeback requests
module mc_wb_fifo
  import regfile_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  wb_req_t                             push_req,
  input  logic                                pop,
  output wb_req_t                             head,
  output logic                                full,
  output logic                                empty,
  output logic [FIFO_DEPTH-1:0]               entry_valid,
  output logic [FIFO_DEPTH-1:0][REG_AW-1:0]   entry_rd
);

  wb_req_t    mem_q [FIFO_DEPTH];
  wb_req_t    mem_d [FIFO_DEPTH];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push_en, pop_en;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_req;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_en) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Slot validity follows from occupancy and the read pointer alone.
  always_comb begin
    entry_valid = '0;
    entry_rd    = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      entry_valid[i] = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i)));
      entry_rd[i]    = mem_q[i].rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between WB and the multi-cycle unit
module regfile_write_arbiter #(
  parameter int XLEN         = regfile_pkg::XLEN,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  regfile_write_arbiter_if.slave    bus
);
  import regfile_pkg::*;

  localparam int              CNT_W     = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

  wb_req_t                           push_req;
  wb_req_t                           head;
  logic                              fifo_full, fifo_empty;
  logic [FIFO_DEPTH-1:0]             entry_valid;
  logic [FIFO_DEPTH-1:0][REG_AW-1:0] entry_rd;

  logic       push, force_mc, grant_wb, grant_mc;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic              reg_write_q, reg_write_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   write_data_q, write_data_d;
  logic              grant_src_q, grant_src_d;
  logic [NUM_REGS-1:0] pending;

  assign push_req.rd   = bus.mc_rd;
  assign push_req.data = bus.mc_data;
  assign push          = bus.mc_valid && !fifo_full;

  mc_wb_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_req    (push_req),
    .pop         (grant_mc),
    .head        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // Once the head has lost STARVE_LIMIT times it takes the port regardless of WB.
  assign force_mc = !fifo_empty && (wait_cnt_q == LIMIT_CNT);
  assign grant_wb = bus.wb_valid && !force_mc;
  assign grant_mc = !grant_wb && !fifo_empty;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (fifo_empty || grant_mc) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != LIMIT_CNT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Writes to x0 still consume a grant but never assert the write enable.
  always_comb begin
    reg_write_d  = 1'b0;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    grant_src_d  = grant_src_q;
    if (grant_wb) begin
      reg_write_d  = (bus.wb_rd != '0);
      rd_d         = bus.wb_rd;
      write_data_d = bus.wb_data;
      grant_src_d  = SRC_WB;
    end else if (grant_mc) begin
      reg_write_d  = (head.rd != '0);
      rd_d         = head.rd;
      write_data_d = head.data;
      grant_src_d  = SRC_MC;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) begin
        pending = pending | rd_onehot(entry_rd[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q   <= '0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
      grant_src_q  <= SRC_WB;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
      grant_src_q  <= grant_src_d;
    end
  end

  assign bus.wb_ready   = !force_mc;
  assign bus.mc_ready   = !fifo_full;
  assign bus.RegWrite   = reg_write_q;
  assign bus.RD         = rd_q;
  assign bus.WriteData  = write_data_q;
  assign bus.grant_src  = grant_src_q;
  assign bus.mc_pending = pending;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.XLEN(64)) bus ();

  regfile_write_arbiter #(.XLEN(64), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 64'h1234;
    bus.mc_valid = 1'b0;
    bus.mc_rd    = 5'd0;
    bus.mc_data  = 64'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.RegWrite !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_regwrite[%0d]: got %b expected 0", i, bus.RegWrite);
      end
    end
    reset        = 1'b1;
    bus.wb_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.mc_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mc_ready: got %b expected 1", bus.mc_ready);
    end
    n_checks++;
    if (bus.mc_pending !== 32'h0) begin
      n_fail++; $display("FAIL reset_mc_pending: got %h expected 0", bus.mc_pending);
    end
    n_checks++;
    if (bus.wb_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_wb_ready: got %b expected 1", bus.wb_ready);
    end
    n_checks++;
    if (bus.RD !== 5'd0 || bus.WriteData !== 64'h0 || bus.grant_src !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%0d data=%h src=%b expected 0/0/0",
               bus.RD, bus.WriteData, bus.grant_src);
    end
  endtask

  task automatic test_wb_only();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 64'hDEAD;
    #1;
    n_checks++;
    if (bus.wb_ready !== 1'b1) begin
      n_fail++; $display("FAIL wb_only_ready: got %b expected 1", bus.wb_ready);
    end
    tick();
    bus.wb_valid = 1'b0;
    n_checks++;
    if (bus.RegWrite !== 1'b1 || bus.RD !== 5'd5 || bus.WriteData !== 64'hDEAD || bus.grant_src !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_only_write: got we=%b rd=%0d data=%h src=%b expected 1/5/dead/0",
               bus.RegWrite, bus.RD, bus.WriteData, bus.grant_src);
    end
    tick();
    n_checks++;
    if (bus.RegWrite !== 1'b0 || bus.RD !== 5'd5) begin
      n_fail++;
      $display("FAIL wb_only_idle_hold: got we=%b rd=%0d expected 0/5", bus.RegWrite, bus.RD);
    end
  endtask

  task automatic test_mc_only();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 64'h11;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd7; bus.mc_data = 64'h77;
    tick();
    n_checks++;
    if (bus.mc_pending !== 32'h80 || bus.RD !== 5'd1 || bus.grant_src !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_first_push: got pend=%h rd=%0d src=%b expected 80/1/0",
               bus.mc_pending, bus.RD, bus.grant_src);
    end
    bus.wb_rd = 5'd2; bus.wb_data = 64'h22;
    bus.mc_rd = 5'd9; bus.mc_data = 64'h99;
    tick();
    n_checks++;
    if (bus.mc_pending !== 32'h280) begin
      n_fail++; $display("FAIL mc_pending_both: got %h expected 280", bus.mc_pending);
    end
    n_checks++;
    if (bus.mc_ready !== 1'b0) begin
      n_fail++; $display("FAIL mc_ready_full: got %b expected 0", bus.mc_ready);
    end
    bus.wb_valid = 1'b0;
    bus.mc_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.RegWrite !== 1'b1 || bus.RD !== 5'd7 || bus.WriteData !== 64'h77 || bus.grant_src !== 1'b1) begin
      n_fail++;
      $display("FAIL mc_write_7: got we=%b rd=%0d data=%h src=%b expected 1/7/77/1",
               bus.RegWrite, bus.RD, bus.WriteData, bus.grant_src);
    end
    n_checks++;
    if (bus.mc_pending !== 32'h200 || bus.mc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mc_after_pop: got pend=%h ready=%b expected 200/1", bus.mc_pending, bus.mc_ready);
    end
    tick();
    n_checks++;
    if (bus.RegWrite !== 1'b1 || bus.RD !== 5'd9 || bus.WriteData !== 64'h99 || bus.grant_src !== 1'b1) begin
      n_fail++;
      $display("FAIL mc_write_9: got we=%b rd=%0d data=%h src=%b expected 1/9/99/1",
               bus.RegWrite, bus.RD, bus.WriteData, bus.grant_src);
    end
    n_checks++;
    if (bus.mc_pending !== 32'h0) begin
      n_fail++; $display("FAIL mc_drained: got %h expected 0", bus.mc_pending);
    end
    tick();
    n_checks++;
    if (bus.RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL mc_idle: got %b expected 0", bus.RegWrite);
    end
  endtask

  task automatic test_starvation();
    logic              exp_ready;
    logic              exp_src;
    logic [4:0]        exp_rd;
    logic [63:0]       exp_data;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd10; bus.wb_data = 64'h1000 + 64'd10;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd3;  bus.mc_data = 64'h33;
    tick();
    for (int k = 0; k <= 8; k++) begin
      bus.mc_valid = (k == 0);
      bus.mc_rd    = 5'd12;
      bus.mc_data  = 64'hCC;
      bus.wb_rd    = 5'(11 + k);
      bus.wb_data  = 64'h1000 + 64'(11 + k);
      #1;
      exp_ready = !(k == 3 || k == 7);
      if (k == 4) begin
        exp_rd = 5'd3;  exp_data = 64'h33; exp_src = 1'b1;
      end else if (k == 8) begin
        exp_rd = 5'd12; exp_data = 64'hCC; exp_src = 1'b1;
      end else begin
        exp_rd = 5'(10 + k); exp_data = 64'h1000 + 64'(10 + k); exp_src = 1'b0;
      end
      n_checks++;
      if (bus.wb_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL starve_wb_ready[%0d]: got %b expected %b", k, bus.wb_ready, exp_ready);
      end
      n_checks++;
      if (bus.RegWrite !== 1'b1 || bus.RD !== exp_rd || bus.WriteData !== exp_data || bus.grant_src !== exp_src) begin
        n_fail++;
        $display("FAIL starve_write[%0d]: got we=%b rd=%0d data=%h src=%b expected 1/%0d/%h/%b",
                 k, bus.RegWrite, bus.RD, bus.WriteData, bus.grant_src, exp_rd, exp_data, exp_src);
      end
      tick();
    end
    bus.wb_valid = 1'b0;
    bus.mc_valid = 1'b0;
    n_checks++;
    if (bus.mc_pending !== 32'h0 || bus.wb_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_drained: got pend=%h wb_ready=%b expected 0/1", bus.mc_pending, bus.wb_ready);
    end
    tick();
  endtask

  task automatic test_x0_drop();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 64'hBAD0;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd0; bus.mc_data = 64'hBAD1;
    #1;
    n_checks++;
    if (bus.wb_ready !== 1'b1 || bus.mc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_handshake: got wb_ready=%b mc_ready=%b expected 1/1", bus.wb_ready, bus.mc_ready);
    end
    tick();
    n_checks++;
    if (bus.RegWrite !== 1'b0 || bus.grant_src !== 1'b0 || bus.mc_pending !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_wb_grant: got we=%b src=%b pend=%h expected 0/0/0",
               bus.RegWrite, bus.grant_src, bus.mc_pending);
    end
    bus.wb_valid = 1'b0;
    bus.mc_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.RegWrite !== 1'b0 || bus.grant_src !== 1'b1 || bus.mc_pending !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_mc_pop: got we=%b src=%b pend=%h expected 0/1/0",
               bus.RegWrite, bus.grant_src, bus.mc_pending);
    end
    tick();
    n_checks++;
    if (bus.RegWrite !== 1'b0 || bus.grant_src !== 1'b1 || bus.mc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_empty: got we=%b src=%b mc_ready=%b expected 0/1/1",
               bus.RegWrite, bus.grant_src, bus.mc_ready);
    end
  endtask

  task automatic test_mid_reset();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd20; bus.wb_data = 64'h2020;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd21; bus.mc_data = 64'h2121;
    tick();
    bus.mc_rd = 5'd22; bus.mc_data = 64'h2222;
    tick();
    n_checks++;
    if (bus.mc_ready !== 1'b0 || bus.RegWrite !== 1'b1 || bus.RD !== 5'd20) begin
      n_fail++;
      $display("FAIL mid_reset_setup: got mc_ready=%b we=%b rd=%0d expected 0/1/20",
               bus.mc_ready, bus.RegWrite, bus.RD);
    end
    bus.wb_valid = 1'b0;
    bus.mc_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.RegWrite !== 1'b0 || bus.RD !== 5'd0 || bus.WriteData !== 64'h0 || bus.grant_src !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got we=%b rd=%0d data=%h src=%b expected 0/0/0/0",
               bus.RegWrite, bus.RD, bus.WriteData, bus.grant_src);
    end
    n_checks++;
    if (bus.mc_pending !== 32'h0 || bus.mc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_fifo: got pend=%h mc_ready=%b expected 0/1", bus.mc_pending, bus.mc_ready);
    end
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.RegWrite !== 1'b0 || bus.mc_pending !== 32'h0) begin
        n_fail++;
        $display("FAIL mid_reset_stale[%0d]: got we=%b pend=%h expected 0/0", i, bus.RegWrite, bus.mc_pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_mc_only();
    test_starvation();
    test_x0_drop();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
